// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store unit with alignment/funct3 checks,
// byte-lane steering, load extension and a bounded-wait memory handshake.
module load_store_unit #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_status,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
    logic              we;
    logic [2:0]        f3;
    logic [31:0]       addr, wdata;
    logic [1:0]        status_next;
    logic [31:0]       rdata_next;
    logic              illegal, misaligned, timeout_hit;
    logic [1:0]        a;
    logic [3:0]        be;
    logic [31:0]       wdata_rep, ext;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    // Classification looks at the raw request; only the next-state logic depends on it.
    assign illegal    = req_we ? !(req_funct3 inside {3'b000, 3'b001, 3'b010})
                               : !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

    assign a         = addr[1:0];
    assign be        = f3[1:0] == 2'b00 ? 4'b0001 << a :
                       f3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_rep = f3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                       f3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;

    assign lane_b = 8'(mem_rdata >> {a, 3'b000});
    assign lane_h = a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ext    = f3 == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
                    f3 == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
                    f3 == 3'b100 ? {24'h0, lane_b} :
                    f3 == 3'b101 ? {16'h0, lane_h} : mem_rdata;

    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = cnt_inc == CNT_W'(TIMEOUT);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        status_next = resp_status;
        rdata_next  = resp_rdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal || misaligned) begin
                        state_next  = RESP;
                        status_next = illegal ? 2'b10 : 2'b01;
                        rdata_next  = '0;
                    end else begin
                        state_next = ACCESS;
                        cnt_next   = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_next  = RESP;
                    status_next = 2'b00;
                    rdata_next  = we ? 32'h0 : ext;
                end else begin
                    cnt_next = cnt_inc;
                    if (timeout_hit) begin
                        state_next  = RESP;
                        status_next = 2'b11;
                        rdata_next  = '0;
                    end
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            we          <= 1'b0;
            f3          <= '0;
            addr        <= '0;
            wdata       <= '0;
            resp_status <= '0;
            resp_rdata  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            resp_status <= status_next;
            resp_rdata  <= rdata_next;
            if (state == IDLE && req_valid) begin
                we    <= req_we;
                f3    <= req_funct3;
                addr  <= req_addr;
                wdata <= req_wdata;
            end
        end
    end

    // Memory-side outputs are gated by state so they read 0 whenever no access is in flight.
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign mem_req    = state == ACCESS;
    assign mem_we     = mem_req && we;
    assign mem_addr   = mem_req ? {addr[31:2], 2'b00} : 32'h0;
    assign mem_be     = mem_req ? be : 4'h0;
    assign mem_wdata  = mem_we ? wdata_rep : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit (lanes, extension, errors, timeout, reset).
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int tests = 0;
    int fails = 0;

    // Observations from the most recent request
    logic        got, mwe, rdy_resp;
    int          lat, nreq;
    logic [3:0]  obe;
    logic [31:0] omwd, oma, ordata;
    logic [1:0]  ost;

    load_store_unit #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_status(resp_status),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Issues one request and plays the memory; ack_at is the 0-based ACCESS cycle that acks (-1 = never).
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] ad,
                           input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
        got = 0; lat = 0; nreq = 0; obe = 0; omwd = 0; mwe = 0; oma = 0;
        ordata = 0; ost = 0; rdy_resp = 1;
        @(negedge clk);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = ad; req_wdata = wd;
        @(negedge clk);
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            lat = i;
            if (mem_req) begin
                if (nreq == 0) begin
                    obe = mem_be; omwd = mem_wdata; mwe = mem_we; oma = mem_addr;
                end
                nreq++;
            end
            if (resp_valid) begin
                got = 1; ordata = resp_rdata; ost = resp_status; rdy_resp = req_ready;
            end else begin
                mem_ack   = mem_req && (nreq - 1 == ack_at);
                mem_rdata = mem_ack ? rd : 32'h0;
                @(negedge clk);
            end
        end
        mem_ack = 0; mem_rdata = 0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL resp_timeout_wait: no resp_valid within 40 cycles (addr %h)", ad);
        end
    endtask

    task automatic test_reset;
        reset = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        tests++;
        if ({req_ready, resp_valid, resp_rdata, resp_status, mem_req, mem_we, mem_addr, mem_be, mem_wdata}
            !== {1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_state: ready=%b rv=%b rd=%h st=%b req=%b we=%b ad=%h be=%b wd=%h, want ready=1 rest 0",
                     req_ready, resp_valid, resp_rdata, resp_status, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
    endtask

    task automatic test_load_word;
        run_req(0, 3'b010, 32'h10, 32'h0, 2, 32'hDEAD_BEEF);
        tests++; if (oma !== 32'h10) begin fails++; $display("FAIL lw_addr: got %h want 00000010", oma); end
        tests++; if (obe !== 4'b1111) begin fails++; $display("FAIL lw_be: got %b want 1111", obe); end
        tests++; if (mwe !== 1'b0) begin fails++; $display("FAIL lw_we: got %b want 0", mwe); end
        tests++; if (lat !== 4 || nreq !== 3) begin fails++; $display("FAIL lw_latency: lat %0d req %0d want 4/3", lat, nreq); end
        tests++; if (ordata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_rdata: got %h want deadbeef", ordata); end
        tests++; if (ost !== 2'b00) begin fails++; $display("FAIL lw_status: got %b want 00", ost); end
        tests++; if (rdy_resp !== 1'b0) begin fails++; $display("FAIL lw_ready_in_resp: got %b want 0", rdy_resp); end
        @(negedge clk);
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL lw_after: rv %b ready %b rd %h want 0/1/deadbeef", resp_valid, req_ready, resp_rdata);
        end
    endtask

    task automatic test_load_ext;
        run_req(0, 3'b000, 32'h21, 32'h0, 0, 32'h1234_80FF);
        tests++; if (ordata !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_rdata: got %h want ffffff80", ordata); end
        tests++; if (obe !== 4'b0010 || oma !== 32'h20) begin fails++; $display("FAIL lb_lane: be %b addr %h want 0010/20", obe, oma); end
        run_req(0, 3'b100, 32'h21, 32'h0, 1, 32'h1234_80FF);
        tests++; if (ordata !== 32'h0000_0080) begin fails++; $display("FAIL lbu_rdata: got %h want 00000080", ordata); end
        run_req(0, 3'b001, 32'h22, 32'h0, 0, 32'h1234_80FF);
        tests++; if (ordata !== 32'h0000_1234 || obe !== 4'b1100) begin fails++; $display("FAIL lh_rdata: got %h be %b want 00001234/1100", ordata, obe); end
        run_req(0, 3'b001, 32'h20, 32'h0, 0, 32'h1234_80FF);
        tests++; if (ordata !== 32'hFFFF_80FF || obe !== 4'b0011) begin fails++; $display("FAIL lh_low: got %h be %b want ffff80ff/0011", ordata, obe); end
        run_req(0, 3'b101, 32'h20, 32'h0, 0, 32'h1234_80FF);
        tests++; if (ordata !== 32'h0000_80FF) begin fails++; $display("FAIL lhu_rdata: got %h want 000080ff", ordata); end
    endtask

    task automatic test_store_lanes;
        run_req(1, 3'b000, 32'h33, 32'h0000_00A5, 0, 32'h5555_5555);
        tests++; if (obe !== 4'b1000 || omwd !== 32'hA5A5_A5A5 || mwe !== 1'b1) begin fails++; $display("FAIL sb_lane: be %b wd %h we %b want 1000/a5a5a5a5/1", obe, omwd, mwe); end
        tests++; if (ordata !== 32'h0 || ost !== 2'b00 || oma !== 32'h30) begin fails++; $display("FAIL sb_resp: rd %h st %b addr %h want 0/00/30", ordata, ost, oma); end
        run_req(1, 3'b001, 32'h32, 32'h0000_BEEF, 3, 32'h0);
        tests++; if (obe !== 4'b1100 || omwd !== 32'hBEEF_BEEF) begin fails++; $display("FAIL sh_lane: be %b wd %h want 1100/beefbeef", obe, omwd); end
        run_req(1, 3'b010, 32'h40, 32'h0102_0304, 0, 32'h0);
        tests++; if (obe !== 4'b1111 || omwd !== 32'h0102_0304) begin fails++; $display("FAIL sw_lane: be %b wd %h want 1111/01020304", obe, omwd); end
    endtask

    task automatic test_errors;
        run_req(0, 3'b000, 32'h50, 32'h0, 0, 32'hCAFE_F00D);
        run_req(0, 3'b010, 32'h6, 32'h0, 0, 32'h1111_1111);
        tests++; if (ost !== 2'b01 || lat !== 1 || nreq !== 0) begin fails++; $display("FAIL lw_misaligned: st %b lat %0d req %0d want 01/1/0", ost, lat, nreq); end
        tests++; if (ordata !== 32'h0) begin fails++; $display("FAIL err_rdata_clear: got %h want 0", ordata); end
        run_req(0, 3'b011, 32'h40, 32'h0, 0, 32'h0);
        tests++; if (ost !== 2'b10 || nreq !== 0) begin fails++; $display("FAIL load_f3_011: st %b req %0d want 10/0", ost, nreq); end
        run_req(1, 3'b100, 32'h40, 32'h0, 0, 32'h0);
        tests++; if (ost !== 2'b10 || nreq !== 0) begin fails++; $display("FAIL store_f3_100: st %b req %0d want 10/0", ost, nreq); end
        run_req(0, 3'b110, 32'h43, 32'h0, 0, 32'h0);
        tests++; if (ost !== 2'b10) begin fails++; $display("FAIL illegal_over_misaligned: st %b want 10", ost); end
        run_req(1, 3'b001, 32'h31, 32'h0, 0, 32'h0);
        tests++; if (ost !== 2'b01 || nreq !== 0) begin fails++; $display("FAIL sh_misaligned: st %b req %0d want 01/0", ost, nreq); end
        run_req(0, 3'b101, 32'h22, 32'h0, 0, 32'h0);
        tests++; if (ost !== 2'b00 || nreq !== 1) begin fails++; $display("FAIL lhu_aligned_ok: st %b req %0d want 00/1", ost, nreq); end
    endtask

    task automatic test_timeout;
        run_req(0, 3'b010, 32'h80, 32'h0, -1, 32'h0);
        tests++; if (nreq !== 15 || lat !== 16) begin fails++; $display("FAIL timeout_len: req %0d lat %0d want 15/16", nreq, lat); end
        tests++; if (ost !== 2'b11 || ordata !== 32'h0) begin fails++; $display("FAIL timeout_status: st %b rd %h want 11/0", ost, ordata); end
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL timeout_ready: ready %b req %b want 1/0", req_ready, mem_req); end
        run_req(0, 3'b010, 32'h84, 32'h0, 14, 32'h7777_0000);
        tests++; if (ost !== 2'b00 || ordata !== 32'h7777_0000 || nreq !== 15) begin fails++; $display("FAIL ack_at_limit: st %b rd %h req %0d want 00/77770000/15", ost, ordata, nreq); end
    endtask

    task automatic test_ack_idle;
        logic seen;
        seen = 0;
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            seen = seen | resp_valid | mem_req;
        end
        mem_ack = 0; mem_rdata = 0;
        tests++; if (seen !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL ack_in_idle: activity %b ready %b want 0/1", seen, req_ready); end
    endtask

    task automatic test_reset_mid_access;
        logic seen;
        seen = 0;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h90;
        @(negedge clk);
        req_valid = 0; req_funct3 = 0; req_addr = 0;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL mid_pre: mem_req %b want 1", mem_req); end
        #2 reset = 1;
        #1;
        tests++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL mid_async: mem_req %b ready %b want 0/1", mem_req, req_ready); end
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        repeat (2) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        reset = 0; mem_ack = 0; mem_rdata = 0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | resp_valid | mem_req;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_no_resp: activity %b want 0", seen); end
        run_req(0, 3'b010, 32'hA0, 32'h0, 0, 32'h0BAD_F00D);
        tests++; if (ordata !== 32'h0BAD_F00D || ost !== 2'b00 || lat !== 2) begin fails++; $display("FAIL mid_recover: rd %h st %b lat %0d want 0badf00d/00/2", ordata, ost, lat); end
    endtask

    initial begin
        test_reset;
        test_load_word;
        test_load_ext;
        test_store_lanes;
        test_errors;
        test_timeout;
        test_ack_idle;
        test_reset_mid_access;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
